axil_slave_mem: RTL and testbench



---
 rtl/axil_slave_mem.sv | 231 +++++++++++++++++++++++
 tb/tb_axil_slave_mem.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/axil_slave_mem.sv
// AXI4-Lite slave over a register-array memory, independent write/read FSMs.
// Define AXIL_MEM_STRB_EN to add the wstrb port and byte-lane writes.
module axil_slave_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 128,
    parameter int RD_LAT = 2
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
`ifdef AXIL_MEM_STRB_EN
    input  logic [DATA_W/8-1:0] wstrb,
`endif
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp
);
    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] idx;
        idx = a >> OFF;
        return idx < ADDR_W'(DEPTH);
    endfunction

    function automatic logic [IW-1:0] to_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] idx;
        idx = a >> OFF;
        return idx[IW-1:0];
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              live_q;

    w_state_t          w_state_q, w_state_d;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]     wstrb_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic              aw_hs, w_hs, commit;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_data;
    logic [NB-1:0]     c_strb;
    logic [NB-1:0]     in_strb;
    logic              c_ok;

    r_state_t          r_state_q, r_state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] raddr_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              ar_hs, load;
    logic [ADDR_W-1:0] r_addr;

`ifdef AXIL_MEM_STRB_EN
    assign in_strb = wstrb;
`else
    assign in_strb = '1;
`endif

    // Readies stay low for one edge after reset so they rise post-deassert.
    always_ff @(posedge aclk) begin
        if (!arst) live_q <= 1'b0;
        else       live_q <= 1'b1;
    end

    assign awready = live_q & ((w_state_q == W_IDLE) | (w_state_q == W_HAVE_D));
    assign wready  = live_q & ((w_state_q == W_IDLE) | (w_state_q == W_HAVE_A));
    assign arready = live_q & (r_state_q == R_IDLE);
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    assign c_addr = (w_state_q == W_HAVE_A) ? waddr_q : awaddr;
    assign c_data = (w_state_q == W_HAVE_D) ? wdata_q : wdata;
    assign c_strb = (w_state_q == W_HAVE_D) ? wstrb_q : in_strb;
    assign c_ok   = in_range(c_addr);

    always_comb begin
        w_state_d = w_state_q;
        commit    = 1'b0;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_state_d = W_RESP;
                    commit    = 1'b1;
                end else if (aw_hs) begin
                    w_state_d = W_HAVE_A;
                end else if (w_hs) begin
                    w_state_d = W_HAVE_D;
                end
            end
            W_HAVE_A: begin
                if (w_hs) begin
                    w_state_d = W_RESP;
                    commit    = 1'b1;
                end
            end
            W_HAVE_D: begin
                if (aw_hs) begin
                    w_state_d = W_RESP;
                    commit    = 1'b1;
                end
            end
            W_RESP: begin
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arst) begin
            w_state_q <= W_IDLE;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) waddr_q <= awaddr;
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= in_strb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= c_ok ? 2'b00 : 2'b11;
            end else if (w_state_q == W_RESP && bready) begin
                bvalid_q <= 1'b0;
                bresp_q  <= 2'b00;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!arst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (commit && c_ok) begin
            for (int b = 0; b < NB; b++) begin
                if (c_strb[b]) mem_q[to_idx(c_addr)][8*b +: 8] <= c_data[8*b +: 8];
            end
        end
    end

    assign ar_hs  = arvalid & arready;
    assign r_addr = (r_state_q == R_IDLE) ? araddr : raddr_q;

    // Data is loaded on the edge that enters R_DATA, so rvalid is registered.
    always_comb begin
        r_state_d = r_state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    cnt_d = 4'(RD_LAT);
                    if (RD_LAT == 0) begin
                        r_state_d = R_DATA;
                        load      = 1'b1;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    r_state_d = R_DATA;
                    load      = 1'b1;
                end
            end
            R_DATA: begin
                if (rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!arst) begin
            r_state_q <= R_IDLE;
            cnt_q     <= '0;
            raddr_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
        end else begin
            r_state_q <= r_state_d;
            cnt_q     <= cnt_d;
            if (ar_hs) raddr_q <= araddr;
            if (load) begin
                rvalid_q <= 1'b1;
                if (in_range(r_addr)) begin
                    rdata_q <= mem_q[to_idx(r_addr)];
                    rresp_q <= 2'b00;
                end else begin
                    rdata_q <= '0;
                    rresp_q <= 2'b11;
                end
            end else if (r_state_q == R_DATA && rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axil_slave_mem.sv
// Directed bench for axil_slave_mem: vector table plus handshake corner cases.
// Strobe checks are compiled in when AXIL_MEM_STRB_EN is defined.
module tb_axil_slave_mem;
    logic        aclk = 1'b0;
    logic        arst = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
    logic        arvalid = 1'b0, rready = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
`ifdef AXIL_MEM_STRB_EN
    logic [3:0]  wstrb = 4'hF;
`endif
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    axil_slave_mem dut (
        .aclk(aclk), .arst(arst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
`ifdef AXIL_MEM_STRB_EN
        .wstrb(wstrb),
`endif
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp);
        bit aw_go, w_go, done;
        done = 0;
        resp = 2'bxx;
        awaddr = a; wdata = d; bready = 1'b1;
`ifdef AXIL_MEM_STRB_EN
        wstrb = s;
`else
        if (s != 4'hF) $display("note: strobe %h ignored in full-word build", s);
`endif
        awvalid = 1'b1; wvalid = 1'b1;
        for (int n = 0; n < 30 && !done; n++) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(negedge aclk);
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
            if (bvalid) begin
                resp = bresp;
                done = 1;
            end
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("wr_done", 64'(done), 64'd1);
        @(negedge aclk);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
        bit ar_go, done;
        int cnt;
        done = 0; cnt = 0; lat = -1; d = 'x; resp = 2'bxx;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            ar_go = arvalid && arready;
            @(negedge aclk);
            if (ar_go) begin
                arvalid = 1'b0;
                cnt = 1;
            end else if (cnt > 0) begin
                cnt++;
            end
            if (rvalid) begin
                d = rdata; resp = rresp; lat = cnt; done = 1;
            end
        end
        arvalid = 1'b0;
        chk("rd_done", 64'(done), 64'd1);
        @(negedge aclk);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  eresp;
        logic [31:0] edata;
    } vec_t;

    vec_t        vt[12];
    logic [1:0]  resp;
    logic [31:0] d;
    int          lat;
    bit          aw_go, w_go, ar_go;

    initial begin
        vt[0]  = '{1, 32'h10,       32'hDEADBEEF, 2'b00, 32'h0};
        vt[1]  = '{0, 32'h10,       32'h0,        2'b00, 32'hDEADBEEF};
        vt[2]  = '{1, 32'h13,       32'hA5A50001, 2'b00, 32'h0};
        vt[3]  = '{0, 32'h12,       32'h0,        2'b00, 32'hA5A50001};
        vt[4]  = '{1, 32'h1FC,      32'hCAFEF00D, 2'b00, 32'h0};
        vt[5]  = '{0, 32'h1FC,      32'h0,        2'b00, 32'hCAFEF00D};
        vt[6]  = '{1, 32'h200,      32'h11111111, 2'b11, 32'h0};
        vt[7]  = '{0, 32'h200,      32'h0,        2'b11, 32'h0};
        vt[8]  = '{0, 32'h0,        32'h0,        2'b00, 32'h0};
        vt[9]  = '{0, 32'hFFFFFFF0, 32'h0,        2'b11, 32'h0};
        vt[10] = '{1, 32'h0,        32'h0BADF00D, 2'b00, 32'h0};
        vt[11] = '{0, 32'h3,        32'h0,        2'b00, 32'h0BADF00D};

        repeat (3) @(negedge aclk);
        chk("rst_outs", {awready, wready, bvalid, bresp, arready, rvalid, rresp},
            64'd0);
        chk("rst_rdata", rdata, 0);
        arst = 1'b1;
        @(negedge aclk);
        chk("rdy_after_rst", {awready, wready, arready}, 64'b111);

        for (int i = 0; i < 12; i++) begin
            if (vt[i].wr) begin
                do_write(vt[i].addr, vt[i].data, 4'hF, resp);
                chk($sformatf("v%0d_bresp", i), resp, vt[i].eresp);
            end else begin
                do_read(vt[i].addr, d, resp, lat);
                chk($sformatf("v%0d_rresp", i), resp, vt[i].eresp);
                chk($sformatf("v%0d_rdata", i), d, vt[i].edata);
                chk($sformatf("v%0d_rlat", i), 64'(lat), 64'd3);
            end
        end

        // W three cycles ahead of AW
        wdata = 32'h12345678; wvalid = 1'b1; bready = 1'b1;
`ifdef AXIL_MEM_STRB_EN
        wstrb = 4'hF;
`endif
        w_go = wvalid && wready;
        @(negedge aclk);
        wvalid = 1'b0;
        chk("wfirst_hs", 64'(w_go), 64'd1);
        chk("wfirst_rdy", {wready, awready}, 64'b01);
        repeat (2) @(negedge aclk);
        chk("wfirst_nob", {bvalid, wready, awready}, 64'b001);
        awaddr = 32'h04; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        chk("wfirst_b", {bvalid, bresp}, 64'b100);
        @(negedge aclk);
        do_read(32'h04, d, resp, lat);
        chk("wfirst_rd", {resp, d}, {2'b00, 32'h12345678});

        // Back-pressure on both response channels
        bready = 1'b0; rready = 1'b0;
        awaddr = 32'h20; wdata = 32'h55AA55AA; araddr = 32'h04;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        aw_go = awvalid && awready;
        w_go  = wvalid && wready;
        ar_go = arvalid && arready;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("stall_hs", {aw_go, w_go, ar_go}, 64'b111);
        for (int n = 0; n < 10 && !(bvalid && rvalid); n++) @(negedge aclk);
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("stall_%0d", n), {bvalid, bresp, rvalid, rresp, rdata},
                {1'b1, 2'b00, 1'b1, 2'b00, 32'h12345678});
            @(negedge aclk);
        end
        bready = 1'b1; rready = 1'b1;
        @(negedge aclk);
        chk("release", {bvalid, rvalid, awready, wready, arready}, 64'b00111);
        do_read(32'h20, d, resp, lat);
        chk("stall_wr_rd", {resp, d}, {2'b00, 32'h55AA55AA});

`ifdef AXIL_MEM_STRB_EN
        do_write(32'h40, 32'hFFFFFFFF, 4'hF, resp);
        do_write(32'h40, 32'h00000000, 4'b0101, resp);
        chk("strb_bresp", resp, 2'b00);
        do_read(32'h40, d, resp, lat);
        chk("strb_rd", d, 32'hFF00FF00);
        do_write(32'h40, 32'h12345678, 4'b0000, resp);
        chk("strb0_bresp", resp, 2'b00);
        do_read(32'h40, d, resp, lat);
        chk("strb0_rd", d, 32'hFF00FF00);
`endif

        // Reset with a read in R_WAIT and a write in W_HAVE_A
        do_write(32'h30, 32'h77777777, 4'hF, resp);
        araddr = 32'h30; arvalid = 1'b1;
        awaddr = 32'h30; awvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0; awvalid = 1'b0;
        chk("mid_state", {rvalid, bvalid, awready, wready, arready}, 64'b00010);
        arst = 1'b0;
        @(negedge aclk);
        chk("midrst_outs", {awready, wready, bvalid, bresp, arready, rvalid, rresp},
            64'd0);
        chk("midrst_rdata", rdata, 0);
        arst = 1'b1;
        @(negedge aclk);
        do_read(32'h30, d, resp, lat);
        chk("midrst_rd", {resp, d}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
